// File: rtl/bus_cycle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_cycle_pkg : S-state encodings and bus strobe slot masks           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package bus_cycle_pkg;

  localparam int N_STATES = 6;

  typedef logic [N_STATES-1:0] state_t;

  localparam int S1_IDX = 0;
  localparam int S2_IDX = 1;
  localparam int S3_IDX = 2;
  localparam int S4_IDX = 3;
  localparam int S5_IDX = 4;
  localparam int S6_IDX = 5;

  localparam state_t S1 = 6'b000001;
  localparam state_t S2 = 6'b000010;
  localparam state_t S3 = 6'b000100;
  localparam state_t S4 = 6'b001000;
  localparam state_t S5 = 6'b010000;
  localparam state_t S6 = 6'b100000;

  localparam state_t ALE_SLOTS  = S1 | S4;
  localparam state_t PSEN_A     = S2 | S3;
  localparam state_t PSEN_B     = S5 | S6;
  // PSEN falls on the last tick of the lead state and stays low for the body state
  localparam state_t PSEN_LEAD  = S2 | S5;
  localparam state_t PSEN_BODY  = S3 | S6;
  localparam state_t XBUS_SLOTS = S1 | S2 | S3;

  function automatic state_t next_state(input state_t s);
    return {s[N_STATES-2:0], s[N_STATES-1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cycle_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_cycle_seq_if : CU decode inputs, bus strobes and cycle status     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface bus_cycle_seq_if
  import bus_cycle_pkg::*;
#(
  parameter int CYC_W = 2
) ();

  logic [CYC_W-1:0] cyc_len;
  logic             xdata;
  logic             xwr;
  logic             ready;
  state_t           s_state;
  logic             phase;
  logic [CYC_W-1:0] cyc_left;
  logic             op_valid;
  logic             instr_end;
  logic             ale;
  logic             psen_n;
  logic             rd_n;
  logic             wr_n;
  logic             wait_active;
  logic             wait_timeout;

  modport master (
    input  cyc_len, xdata, xwr, ready,
    output s_state, phase, cyc_left, op_valid, instr_end,
    output ale, psen_n, rd_n, wr_n, wait_active, wait_timeout
  );

  modport slave (
    output cyc_len, xdata, xwr, ready,
    input  s_state, phase, cyc_left, op_valid, instr_end,
    input  ale, psen_n, rd_n, wr_n, wait_active, wait_timeout
  );

endinterface
`default_nettype wire

// File: rtl/bus_state_ticker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_state_ticker : tick counter, one-hot S-state and READY wait hold  |
// | Optional macro BUS_WAIT_EN enables the wait hold.   Rev 1.0           |
// +----------------------------------------------------------------------+
module bus_state_ticker
  import bus_cycle_pkg::*;
#(
  parameter int PH_PER_S = 2,
  parameter int WAIT_MAX = 7
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   ready,
  input  logic   bus_active,
  output state_t state,
  output logic   phase,
  output logic   tick_zero,
  output state_t state_nxt,
  output logic   last_nxt,
  output logic   hold,
  output logic   wrap,
  output logic   wait_active,
  output logic   wait_timeout
);

  localparam int TICK_W = $clog2(PH_PER_S);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PH_PER_S - 1);

  logic              run;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] tick_nxt;
  logic              last;

  assign last      = (tick == TICK_LAST);
  assign tick_zero = (tick == '0);

`ifdef BUS_WAIT_EN
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  logic [WCNT_W-1:0] wait_cnt;
  logic              stall;
  logic              timeout;

  assign stall   = run && state[S3_IDX] && last && bus_active && !ready;
  assign hold    = stall && (wait_cnt < WCNT_W'(WAIT_MAX));
  assign timeout = stall && !hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt     <= '0;
      wait_active  <= 1'b0;
      wait_timeout <= 1'b0;
    end else begin
      wait_active  <= hold;
      wait_timeout <= timeout;
      if (hold)
        wait_cnt <= wait_cnt + 1'b1;
      else if (state_nxt[S4_IDX] && !state[S4_IDX])
        wait_cnt <= '0;
    end
  end
`else
  logic unused_wait;
  assign unused_wait  = ^{ready, bus_active, 1'(WAIT_MAX)};
  assign hold         = 1'b0;
  assign wait_active  = 1'b0;
  assign wait_timeout = 1'b0;
`endif

  always_comb begin
    tick_nxt  = tick;
    state_nxt = state;
    if (run && !hold) begin
      if (last) begin
        tick_nxt  = '0;
        state_nxt = next_state(state);
      end else begin
        tick_nxt = tick + 1'b1;
      end
    end
  end

  assign last_nxt = (tick_nxt == TICK_LAST);
  assign wrap     = run && !hold && last && state[S6_IDX];

  // The first clock out of reset holds S1 tick 0 so the registered strobes can catch up
  always_ff @(posedge clk) begin
    if (reset) begin
      run   <= 1'b0;
      tick  <= '0;
      state <= S1;
      phase <= 1'b0;
    end else begin
      run   <= 1'b1;
      tick  <= tick_nxt;
      state <= state_nxt;
      phase <= last_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_cycle_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_cycle_seq : MCU51 machine-cycle sequencer and bus strobe driver   |
// | Optional macro BUS_WAIT_EN enables READY wait states.   Rev 1.0       |
// +----------------------------------------------------------------------+
module bus_cycle_seq
  import bus_cycle_pkg::*;
#(
  parameter int PH_PER_S = 2,
  parameter int CYC_W    = 2,
  parameter int WAIT_MAX = 7
) (
  input  logic            clk,
  input  logic            reset,
  bus_cycle_seq_if.master bus
);

  state_t           state;
  state_t           state_nxt;
  logic             phase;
  logic             tick_zero;
  logic             last_nxt;
  logic             hold;
  logic             wrap;
  logic             bus_active;

  logic [CYC_W-1:0] cyc_left;
  logic [CYC_W-1:0] cyc_left_nxt;
  logic             first;
  logic             first_nxt;
  logic             xcyc;
  logic             xcyc_nxt;
  logic             xd;
  logic             xw;
  logic             sample;

  logic             ale_r;
  logic             psen_n_r;
  logic             rd_n_r;
  logic             wr_n_r;
  logic             op_valid_r;
  logic             instr_end_r;

  logic             ale_nxt;
  logic             fetch_nxt;
  logic             psen_lo_nxt;
  logic             rd_lo_nxt;
  logic             wr_lo_nxt;

  assign bus_active = !psen_n_r || !rd_n_r || !wr_n_r;

  bus_state_ticker #(
    .PH_PER_S (PH_PER_S),
    .WAIT_MAX (WAIT_MAX)
  ) u_ticker (
    .clk          (clk),
    .reset        (reset),
    .ready        (bus.ready),
    .bus_active   (bus_active),
    .state        (state),
    .phase        (phase),
    .tick_zero    (tick_zero),
    .state_nxt    (state_nxt),
    .last_nxt     (last_nxt),
    .hold         (hold),
    .wrap         (wrap),
    .wait_active  (bus.wait_active),
    .wait_timeout (bus.wait_timeout)
  );

  assign sample = first && state[S4_IDX] && tick_zero;

  // xcyc marks the data-transfer machine cycle that follows the MOVX opcode fetch
  always_comb begin
    cyc_left_nxt = cyc_left;
    first_nxt    = first;
    xcyc_nxt     = xcyc;
    if (sample) begin
      cyc_left_nxt = (bus.xdata && bus.cyc_len == '0) ? CYC_W'(1) : bus.cyc_len;
    end else if (wrap) begin
      xcyc_nxt = first && xd && (cyc_left != '0);
      if (cyc_left != '0) begin
        cyc_left_nxt = cyc_left - 1'b1;
        first_nxt    = 1'b0;
      end else begin
        first_nxt    = 1'b1;
      end
    end
  end

  // Strobes are computed from the next state so they register in step with it
  assign ale_nxt     = (|(state_nxt & ALE_SLOTS)) && !(xcyc_nxt && state_nxt[S1_IDX]);
  assign fetch_nxt   = (|(state_nxt & PSEN_BODY)) || ((|(state_nxt & PSEN_LEAD)) && last_nxt);
  assign psen_lo_nxt = fetch_nxt
                       && !(xcyc_nxt && (|(state_nxt & PSEN_A)))
                       && !(first_nxt && xd && (|(state_nxt & PSEN_B)));
  assign rd_lo_nxt   = xcyc_nxt && !xw && (|(state_nxt & XBUS_SLOTS));
  assign wr_lo_nxt   = xcyc_nxt &&  xw && (|(state_nxt & XBUS_SLOTS));

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_left    <= '0;
      first       <= 1'b1;
      xcyc        <= 1'b0;
      xd          <= 1'b0;
      xw          <= 1'b0;
      ale_r       <= 1'b0;
      psen_n_r    <= 1'b1;
      rd_n_r      <= 1'b1;
      wr_n_r      <= 1'b1;
      op_valid_r  <= 1'b0;
      instr_end_r <= 1'b0;
    end else begin
      cyc_left    <= cyc_left_nxt;
      first       <= first_nxt;
      xcyc        <= xcyc_nxt;
      if (sample) begin
        xd <= bus.xdata;
        xw <= bus.xwr;
      end
      ale_r       <= ale_nxt;
      psen_n_r    <= !psen_lo_nxt;
      rd_n_r      <= !rd_lo_nxt;
      wr_n_r      <= !wr_lo_nxt;
      op_valid_r  <= state_nxt[S3_IDX] && last_nxt && first_nxt && !hold;
      instr_end_r <= state_nxt[S6_IDX] && last_nxt && (cyc_left_nxt == '0);
    end
  end

  assign bus.s_state   = state;
  assign bus.phase     = phase;
  assign bus.cyc_left  = cyc_left;
  assign bus.op_valid  = op_valid_r;
  assign bus.instr_end = instr_end_r;
  assign bus.ale       = ale_r;
  assign bus.psen_n    = psen_n_r;
  assign bus.rd_n      = rd_n_r;
  assign bus.wr_n      = wr_n_r;

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_bus_cycle_seq : directed + random bench with a clock-position model|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_bus_cycle_seq;
  import bus_cycle_pkg::*;

  localparam int PH   = 2;
  localparam int CW   = 2;
  localparam int WMAX = 7;
  localparam int VW   = 15 + CW;

  logic clk = 1'b0;
  logic reset;

  bus_cycle_seq_if #(.CYC_W(CW)) bus ();

  bus_cycle_seq #(
    .PH_PER_S (PH),
    .CYC_W    (CW),
    .WAIT_MAX (WMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] obs_v;
  assign obs_v = {bus.s_state, bus.phase, bus.cyc_left, bus.op_valid, bus.instr_end,
                  bus.ale, bus.psen_n, bus.rd_n, bus.wr_n, bus.wait_active, bus.wait_timeout};

  int cnt_cmp = 0;
  int cnt_bad = 0;

  // Model: position within the machine cycle, machine-cycle index within the instruction
  bit m_pre = 1'b1;
  int m_t = 0, m_mc = 0, m_cl = 0, m_wcnt = 0;
  bit m_xd = 1'b0, m_xw = 1'b0, m_held = 1'b0, m_to = 1'b0;

  logic [CW-1:0] nxt_len = '0;
  logic          nxt_xd  = 1'b0;
  logic          nxt_xw  = 1'b0;

  function automatic logic [VW-1:0] expv();
    int   s;
    logic last, dcyc, ale, psl, rdl, wrl, opv, ie;
    if (m_pre) return {6'b000001, 1'b0, CW'(0), 8'b0001_1100};
    s    = m_t / PH;
    last = (m_t % PH) == PH - 1;
    dcyc = (m_mc == 1) && m_xd;
    ale  = ((s == 0) && !dcyc) || (s == 3);
    psl  = ((((s == 1) && last) || (s == 2)) && !dcyc)
        || ((((s == 4) && last) || (s == 5)) && !((m_mc == 0) && m_xd));
    rdl  = dcyc && !m_xw && (s <= 2);
    wrl  = dcyc &&  m_xw && (s <= 2);
    opv  = (m_mc == 0) && (s == 2) && last && !m_held;
    ie   = (s == 5) && last && (m_cl == 0);
    return {6'(1 << s), last, CW'(m_cl), opv, ie, ale, !psl, !rdl, !wrl, logic'(m_held), logic'(m_to)};
  endfunction

  task automatic model_edge();
    logic [VW-1:0] cur;
    bit busy, hold;
    cur  = expv();
    busy = !cur[4] || !cur[3] || !cur[2];
    if (reset) begin
      m_pre = 1; m_t = 0; m_mc = 0; m_cl = 0; m_xd = 0; m_xw = 0;
      m_held = 0; m_wcnt = 0; m_to = 0;
      return;
    end
    if (m_pre) begin
      m_pre = 0; m_held = 0; m_to = 0;
      return;
    end
    if (m_mc == 0 && m_t == 3 * PH) begin
      m_xd = bus.xdata;
      m_xw = bus.xwr;
      m_cl = (bus.xdata && bus.cyc_len == '0) ? 1 : int'(bus.cyc_len);
    end
    m_to = 0;
    hold = 0;
`ifdef BUS_WAIT_EN
    if (m_t == 3 * PH - 1 && busy && !bus.ready) begin
      if (m_wcnt < WMAX) begin hold = 1; m_wcnt++; end
      else m_to = 1;
    end
`else
    if (busy && 1'b0) hold = 1;
`endif
    m_held = hold;
    if (!hold) begin
      if (m_t == 6 * PH - 1) begin
        m_t = 0;
        if (m_cl > 0) begin m_cl--; m_mc++; end
        else m_mc = 0;
      end else begin
        m_t++;
      end
      if (m_t == 3 * PH) m_wcnt = 0;
    end
  endtask

  task automatic check();
    logic [VW-1:0] e;
    e = expv();
    cnt_cmp++;
    assert (obs_v === e) else begin
      cnt_bad++;
      $error("FAIL outputs @%0t observed=%h expected=%h", $time, obs_v, e);
    end
    cnt_cmp++;
    assert ((bus.rd_n | bus.wr_n) === 1'b1) else begin
      cnt_bad++;
      $error("FAIL rd_wr_exclusive @%0t observed rd_n=%b wr_n=%b expected one high", $time, bus.rd_n, bus.wr_n);
    end
  endtask

  task automatic step(input logic rst_v, input logic rdy_v);
    reset     = rst_v;
    bus.ready = rdy_v;
    if (!m_pre && m_mc == 0 && m_t == 3 * PH) begin
      bus.cyc_len = nxt_len; bus.xdata = nxt_xd; bus.xwr = nxt_xw;
    end else begin
      bus.cyc_len = CW'($urandom); bus.xdata = 1'($urandom); bus.xwr = 1'($urandom);
    end
    @(posedge clk);
    model_edge();
    #1 check();
  endtask

  initial begin
    reset = 1'b1; bus.ready = 1'b1; bus.cyc_len = '0; bus.xdata = 1'b0; bus.xwr = 1'b0;
    repeat (3) step(1'b1, 1'b1);

    // plain single-cycle fetches: two instructions, clk 0..23
    repeat (24) step(1'b0, 1'b1);
    // three machine cycles
    nxt_len = 2'd2;
    repeat (36) step(1'b0, 1'b1);
    // MOVX read
    nxt_len = 2'd1; nxt_xd = 1'b1; nxt_xw = 1'b0;
    repeat (24) step(1'b0, 1'b1);
    // MOVX write aborted by reset during clk 16, then a plain fetch
    nxt_xw = 1'b1;
    repeat (17) step(1'b0, 1'b1);
    nxt_len = 2'd0; nxt_xd = 1'b0; nxt_xw = 1'b0;
    step(1'b1, 1'b1);
    repeat (14) step(1'b0, 1'b1);
    // MOVX with cyc_len 0 still gets its data cycle
    nxt_len = 2'd0; nxt_xd = 1'b1; nxt_xw = 1'b1;
    repeat (24) step(1'b0, 1'b1);

`ifdef BUS_WAIT_EN
    nxt_len = 2'd0; nxt_xd = 1'b0; nxt_xw = 1'b0;
    step(1'b1, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b0, (k >= 6 && k <= 8) ? 1'b0 : 1'b1);
    nxt_len = 2'd1;
    step(1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b1);
`endif

    for (int i = 0; i < 1500; i++) begin
      if (!m_pre && m_mc == 0 && m_t == 3 * PH) begin
        nxt_len = CW'($urandom); nxt_xd = 1'($urandom); nxt_xw = 1'($urandom);
      end
      step($urandom_range(399) == 0, $urandom_range(3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
    $finish;
  end

endmodule
`default_nettype wire
